llr_cw_buffer: RTL
==================

# llr_cw_buffer

Codeword buffer between the LLR calculation stage and the LDPC decoder. Collects the 8-bit 3Q4 LLR stream into codeword-sized blocks in a two-bank ping-pong RAM. Each completed block is released to the decoder as a framed stream with valid/ready backpressure. Input-side continuity is preserved while the decoder drains the other bank.

## Interface
- CW_LEN, 648, LLRs per LDPC codeword (2..1024)
- AW, 10, bank address width, 2^AW >= CW_LEN
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- di  in  8  signed 3Q4 LLR from LLR calculation
- di_vld  in  1  di valid, no backpressure upstream
- di_last  in  1  with di_vld: last LLR of the frame; forces padding of the partial codeword
- do  out  8  signed 3Q4 LLR to decoder
- do_vld  out  1  do valid
- do_sop  out  1  first LLR of codeword (qualified by do_vld)
- do_eop  out  1  last LLR of codeword (qualified by do_vld)
- do_rdy  in  1  decoder accepts do when do_vld && do_rdy
- ovf  out  1  sticky: input sample dropped; cleared only by reset

## Operation
- Storage: two banks of CW_LEN x 8, 1-cycle synchronous read; bank flags full[1:0].
- Input clamp: di == 8'h80 is written as 8'h81. All other values pass unchanged.
- Write FSM, states W_FILL and W_PAD:
  - W_FILL: on di_vld, if full[wb]==0, write to bank wb at wa and increment wa.
  - On the write with wa==CW_LEN-1: set full[wb], toggle wb, wa=0.
  - On a write with di_last and wa<CW_LEN-1: go to W_PAD.
  - If full[wb]==1 on di_vld: drop the sample, set ovf, wa unchanged.
- W_PAD: write 8'h00 (erasure) each cycle until wa==CW_LEN-1 is written. Then set full[wb], toggle wb, return to W_FILL.
  - di_vld during W_PAD is dropped and sets ovf.
  - di_last with wa==CW_LEN-1 completes normally, with no padding.
- Read FSM, states R_IDLE, R_PREF, R_STREAM:
  - R_IDLE: when full[rb], issue ra=0 and go to R_PREF.
  - R_PREF: RAM data lands in the output register; do_vld=1, do_sop=1; go to R_STREAM.
  - R_STREAM: each do_vld&&do_rdy advances to the next entry. do is held stable while !do_rdy.
  - A one-entry skid register absorbs the RAM latency, so continuous do_rdy gives one LLR per cycle.
  - do_eop=1 on entry CW_LEN-1. Its acceptance clears full[rb], toggles rb, and returns to R_IDLE.
- Simultaneous events:
  - Clearing full[rb] and the writer completing bank rb in the same cycle cannot occur, because the writer only fills a bank with full==0.
  - Writer-set and reader-clear on different banks in the same cycle are both applied.
- Reset (any time): wb=rb=0, wa=ra=0, full=0, ovf=0, FSM to W_FILL/R_IDLE. Partial codewords are discarded.

## Timing
- Reset values: do=0, do_vld=0, do_sop=0, do_eop=0, ovf=0.
- The input write is registered. Latency from the last di_vld of a codeword (cycle T) to first do_vld is cycle T+3: full set at T+1, R_PREF at T+2, do_vld at T+3.
- Throughput with do_rdy=1: CW_LEN beats in CW_LEN consecutive cycles, then 2 idle cycles (R_IDLE, R_PREF) before the next codeword's first beat, if that bank is full.
- ovf asserts the cycle after the dropped di_vld.
- Padding: one pad word per cycle. The padded bank is full on the cycle after the last pad write.

## Test plan
- CW_LEN=8, 16 LLRs 0x01..0x10 back-to-back, do_rdy=1 -> two codewords 0x01..0x08 and 0x09..0x10. do_sop on 0x01/0x09, do_eop on 0x08/0x10. First do_vld 3 cycles after the 8th input. ovf=0.
- CW_LEN=8, input 0x80, 0x7F, 0x81 -> output 0x81, 0x7F, 0x81.
- CW_LEN=8, 5 LLRs with di_last on the 5th -> codeword = 5 inputs then three 0x00. do_eop on the 8th beat.
- CW_LEN=8, do_rdy toggling 1,0,0,1 pattern -> no duplicated or lost beat. do stable while do_rdy=0. Output order matches input.
- CW_LEN=8, do_rdy=0, 24 inputs -> first 16 stored, last 8 dropped, ovf=1 after the 17th. Then do_rdy=1 -> exactly 2 codewords out.
- Reset asserted mid-codeword (after 3 of 8 outputs) -> next cycle do_vld=0, ovf=0. A subsequent 8 inputs produce a clean codeword starting at bank 0.

Source files
------------

// File: rtl/llr_cw_buffer_if.sv
// LLR codeword buffer stream bundle.
// Input LLR stream, framed output stream, sticky overflow flag.
interface llr_cw_buffer_if;
  logic [7:0] di;
  logic       di_vld;
  logic       di_last;
  logic [7:0] dout;
  logic       do_vld;
  logic       do_sop;
  logic       do_eop;
  logic       do_rdy;
  logic       ovf;

  modport master (
    output di, di_vld, di_last, do_rdy,
    input  dout, do_vld, do_sop, do_eop, ovf
  );

  modport slave (
    input  di, di_vld, di_last, do_rdy,
    output dout, do_vld, do_sop, do_eop, ovf
  );
endinterface

// File: rtl/llr_cw_buffer.sv
// Ping-pong codeword buffer between LLR calc and LDPC decoder.
// Ports: clk, rst (sync, active-low), bus (slave: di/di_vld/di_last in, dout/do_* out, do_rdy in, ovf out).
module llr_cw_buffer #(
  parameter int CW_LEN = 648,
  parameter int AW     = 10
) (
  input logic            clk,
  input logic            rst,
  llr_cw_buffer_if.slave bus
);

  localparam logic [AW-1:0] LAST = AW'(CW_LEN - 1);
  localparam logic [AW:0]   CWL  = (AW + 1)'(CW_LEN);

  typedef enum logic {W_FILL, W_PAD} w_st_t;
  typedef enum logic [1:0] {R_IDLE, R_PREF, R_STREAM} r_st_t;

  logic [7:0] mem [0:(1 << (AW + 1)) - 1];

  w_st_t       w_st, w_nx;
  logic        wb, wb_nx;
  logic [AW-1:0] wa, wa_nx;
  logic        we;
  logic [7:0]  wdat;
  logic        set_full;
  logic        drop;
  logic [1:0]  full;
  logic        ovf_q;

  r_st_t       r_st, r_nx;
  logic        rb, rb_nx;
  logic [AW:0] ra, ra_nx;
  logic        rd_en;
  logic        clr_full;
  logic [AW-1:0] pcnt, pcnt_nx;

  logic        p_vld;
  logic [7:0]  p_dat;
  logic        s_vld;
  logic [7:0]  s_dat;
  logic        o_vld;
  logic [7:0]  o_dat;
  logic        pop;
  logic [1:0]  occ;
  logic        issue;

  always_comb begin
    w_nx     = w_st;
    wb_nx    = wb;
    wa_nx    = wa;
    we       = 1'b0;
    wdat     = 8'h00;
    set_full = 1'b0;
    drop     = 1'b0;
    unique case (w_st)
      W_FILL: begin
        if (bus.di_vld) begin
          if (full[wb]) begin
            drop = 1'b1;
          end else begin
            we   = 1'b1;
            // -128 has no positive twin; keep the LLR symmetric
            wdat = (bus.di == 8'h80) ? 8'h81 : bus.di;
            if (wa == LAST) begin
              set_full = 1'b1;
              wb_nx    = ~wb;
              wa_nx    = '0;
            end else begin
              wa_nx = wa + 1'b1;
              if (bus.di_last) w_nx = W_PAD;
            end
          end
        end
      end
      W_PAD: begin
        we   = 1'b1;
        drop = bus.di_vld;
        if (wa == LAST) begin
          set_full = 1'b1;
          wb_nx    = ~wb;
          wa_nx    = '0;
          w_nx     = W_FILL;
        end else begin
          wa_nx = wa + 1'b1;
        end
      end
      default: w_nx = W_FILL;
    endcase
  end

  // occupancy of out+skid after this edge, counting a read landing now
  assign pop   = o_vld & bus.do_rdy;
  assign occ   = 2'(o_vld) + 2'(s_vld) + 2'(p_vld) - 2'(pop);
  assign issue = (ra < CWL) && (occ <= 2'd1);

  always_comb begin
    r_nx     = r_st;
    rb_nx    = rb;
    ra_nx    = ra;
    rd_en    = 1'b0;
    clr_full = 1'b0;
    pcnt_nx  = pcnt;
    unique case (r_st)
      R_IDLE: begin
        if (full[rb]) begin
          rd_en = 1'b1;
          ra_nx = ra + 1'b1;
          r_nx  = R_PREF;
        end
      end
      R_PREF: begin
        r_nx = R_STREAM;
        if (issue) begin
          rd_en = 1'b1;
          ra_nx = ra + 1'b1;
        end
      end
      R_STREAM: begin
        if (issue) begin
          rd_en = 1'b1;
          ra_nx = ra + 1'b1;
        end
        if (pop) begin
          if (pcnt == LAST) begin
            clr_full = 1'b1;
            rb_nx    = ~rb;
            ra_nx    = '0;
            pcnt_nx  = '0;
            r_nx     = R_IDLE;
          end else begin
            pcnt_nx = pcnt + 1'b1;
          end
        end
      end
      default: r_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[{wb, wa}] <= wdat;
    if (rd_en) p_dat <= mem[{rb, ra[AW-1:0]}];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_st  <= W_FILL;
      wb    <= 1'b0;
      wa    <= '0;
      ovf_q <= 1'b0;
      full  <= 2'b00;
      r_st  <= R_IDLE;
      rb    <= 1'b0;
      ra    <= '0;
      pcnt  <= '0;
    end else begin
      w_st <= w_nx;
      wb   <= wb_nx;
      wa   <= wa_nx;
      if (drop) ovf_q <= 1'b1;
      full <= (full | (set_full ? (wb ? 2'b10 : 2'b01) : 2'b00))
            & ~(clr_full ? (rb ? 2'b10 : 2'b01) : 2'b00);
      r_st <= r_nx;
      rb   <= rb_nx;
      ra   <= ra_nx;
      pcnt <= pcnt_nx;
    end
  end

  // output register with one-entry skid behind it
  always_ff @(posedge clk) begin
    if (!rst) begin
      p_vld <= 1'b0;
      s_vld <= 1'b0;
      s_dat <= 8'h00;
      o_vld <= 1'b0;
      o_dat <= 8'h00;
    end else begin
      p_vld <= rd_en;
      if (!o_vld || pop) begin
        if (s_vld) begin
          o_dat <= s_dat;
          o_vld <= 1'b1;
          s_vld <= p_vld;
          if (p_vld) s_dat <= p_dat;
        end else if (p_vld) begin
          o_dat <= p_dat;
          o_vld <= 1'b1;
        end else begin
          o_vld <= 1'b0;
        end
      end else if (p_vld) begin
        s_dat <= p_dat;
        s_vld <= 1'b1;
      end
    end
  end

  assign bus.dout   = o_dat;
  assign bus.do_vld = o_vld;
  assign bus.do_sop = o_vld && (pcnt == '0);
  assign bus.do_eop = o_vld && (pcnt == LAST);
  assign bus.ovf    = ovf_q;

endmodule
